// File: rtl/uart_boot_loader.sv
// uart_boot_loader: assembles the UART RX byte stream into 32-bit
// little-endian words, writes them into consecutive IMEM entries and holds
// the CPU in reset until the image is complete or the host goes idle.
module uart_boot_loader #(
  parameter int IMEM_ENTRIES = 4096,
  parameter int ADDR_W       = $clog2(IMEM_ENTRIES),
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_rvalid_i,
  output logic              rx_rready_o,
  input  logic [7:0]        rx_rdata_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic [ADDR_W:0]   words_o
);

  // Idle counter is at least one bit wide so the design still elaborates
  // with the timeout disabled.
  localparam int IDLE_W    = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int IDLE_LAST = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;

  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_FIRE  = IDLE_W'(IDLE_LAST);
  localparam logic [ADDR_W:0]   FULL_WORDS = (ADDR_W + 1)'(IMEM_ENTRIES);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q;
  logic [31:0]         asm_q;
  logic [31:0]         word_d;
  logic [IDLE_W-1:0]   idle_q;
  logic                started_q;
  logic                flush_q;
  logic [ADDR_W:0]     words_q;
  logic [ADDR_W:0]     words_inc;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                rready_q;
  logic                cpu_rst_q;
  logic                done_q;
  logic                accept;
  logic                timeout;

  // rready is registered, so it is already 0 in WRITE/DONE.
  assign accept    = rx_rvalid_i & rready_q;
  assign words_inc = words_q + 1'b1;

  // idle_q counts idle LOAD cycles since the last accepted byte; the timeout
  // fires on the edge that would bring it to IDLE_TIMEOUT. An arriving byte
  // always wins over the timeout.
  assign timeout = (IDLE_TIMEOUT != 0) && started_q && (state_q == S_LOAD)
                   && !accept && (idle_q == IDLE_FIRE);

  // Next-state selection and the word as it will be written.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    word_d  = asm_q;
    if (accept) begin
      word_d[{lane_q, 3'b000} +: 8] = rx_rdata_i;
    end
    case (state_q)
      S_LOAD: begin
        if (accept && (lane_q == 2'd3)) begin
          state_d = S_WRITE;
        end else if (timeout) begin
          // A partial word is flushed with zero upper lanes; an aligned
          // stream simply stops.
          state_d = (lane_q != 2'd0) ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: state_d = ((words_inc == FULL_WORDS) || flush_q) ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end

  // State and registered control outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q   <= S_LOAD;
      rready_q  <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rready_q  <= (state_d == S_LOAD);
      cpu_rst_q <= (state_d != S_DONE);
      done_q    <= (state_d == S_DONE);
    end
  end

  // Byte assembly, idle counting, word capture and the word counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q    <= '0;
      asm_q     <= '0;
      idle_q    <= '0;
      started_q <= 1'b0;
      flush_q   <= 1'b0;
      words_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      if (accept) begin
        asm_q[{lane_q, 3'b000} +: 8] <= rx_rdata_i;
        lane_q    <= lane_q + 2'd1;
        started_q <= 1'b1;
      end else if (state_q == S_WRITE) begin
        asm_q  <= '0;
        lane_q <= '0;
      end

      if (state_q == S_LOAD) begin
        if (accept) begin
          idle_q <= '0;
        end else if (started_q && (idle_q != IDLE_MAX)) begin
          idle_q <= idle_q + 1'b1;
        end
      end

      // Address and data are captured on entry to WRITE and then held.
      if ((state_q == S_LOAD) && (state_d == S_WRITE)) begin
        addr_q  <= words_q[ADDR_W-1:0];
        wdata_q <= word_d;
        flush_q <= timeout;
      end

      if (state_q == S_WRITE) begin
        words_q <= words_inc;
      end
    end
  end

  // Write strobe decodes the state directly, so reset drops it at once.
  assign imem_we_o    = (state_q == S_WRITE);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign rx_rready_o  = rready_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign done_o       = done_q;
  assign words_o      = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: two instances with IMEM_ENTRIES=4, one
// without idle timeout (index 0) and one with IDLE_TIMEOUT=8 (index 1).
// The driver feeds bytes and a byte-level reference model pushes expected
// IMEM writes into a queue; per-instance monitors pop and compare.
module tb_uart_boot_loader;

  localparam int ENTRIES = 4;
  localparam int TO      = 8;

  typedef struct {
    int          inst;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rvalid [2];
  logic [7:0]  rdata  [2];
  logic        rready [2];
  logic        we     [2];
  logic [1:0]  addr   [2];
  logic [31:0] wdata  [2];
  logic        cpu_rst[2];
  logic        done   [2];
  logic [2:0]  words  [2];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  // Reference model state: bytes of the word in progress, words written.
  logic [7:0] byte_q[$];
  int         mwords;
  int         last_edge;
  int         exp_done_lo;
  int         exp_done_hi;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int   n_writes = 0;
    int   done_edge = -1;
    bit   done_prev = 1'b0;
    exp_t e;

    uart_boot_loader #(
      .IMEM_ENTRIES (ENTRIES),
      .IDLE_TIMEOUT ((g == 0) ? 0 : TO)
    ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .rx_rvalid_i  (rvalid[g]),
      .rx_rready_o  (rready[g]),
      .rx_rdata_i   (rdata[g]),
      .imem_we_o    (we[g]),
      .imem_addr_o  (addr[g]),
      .imem_wdata_o (wdata[g]),
      .cpu_rst_o    (cpu_rst[g]),
      .done_o       (done[g]),
      .words_o      (words[g])
    );

    // Monitor: compare every IMEM write against the scoreboard head.
    always @(negedge clk) begin
      if (rst_n) begin
        if (we[g]) begin
          n_writes <= n_writes + 1;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write inst%0d: addr 0x%0h data 0x%0h, no write expected", g, addr[g], wdata[g]);
          end else begin
            e = exp_q.pop_front();
            check("wr_inst", 32'(g), 32'(e.inst));
            check("wr_addr", 32'(addr[g]), 32'(e.addr));
            check("wr_data", wdata[g], e.data);
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        if (done[g] && !done_prev) done_edge <= cyc;
      end
      done_prev <= done[g];
    end
  end

  function automatic int get_writes(input int idx);
    if (idx == 0) return g_dut[0].n_writes;
    return g_dut[1].n_writes;
  endfunction

  function automatic int get_done_edge(input int idx);
    if (idx == 0) return g_dut[0].done_edge;
    return g_dut[1].done_edge;
  endfunction

  function automatic logic [31:0] model_word();
    logic [31:0] w = '0;
    for (int k = 0; k < byte_q.size(); k++) w = w | (32'(byte_q[k]) << (8 * k));
    return w;
  endfunction

  task automatic model_reset();
    byte_q.delete();
    mwords      = 0;
    last_edge   = -1;
    exp_done_lo = -1;
    exp_done_hi = -1;
  endtask

  // A byte accepted at clock edge 'edge': every fourth byte becomes a write
  // in the cycle right after that edge; the last word ends the load.
  task automatic model_accept(input int idx, input logic [7:0] b, input int edge_no);
    exp_t x;
    byte_q.push_back(b);
    last_edge = edge_no;
    if (byte_q.size() == 4) begin
      x.inst = idx; x.addr = mwords; x.data = model_word(); x.cyc = edge_no;
      exp_q.push_back(x);
      mwords++;
      byte_q.delete();
      if (mwords == ENTRIES) begin
        exp_done_lo = edge_no + 1;
        exp_done_hi = edge_no + 1;
      end
    end
  endtask

  // Host goes silent: a partial word is written TO cycles after the last
  // byte and the load ends one cycle later.
  task automatic model_flush(input int idx);
    exp_t x;
    if (byte_q.size() != 0) begin
      x.inst = idx; x.addr = mwords; x.data = model_word(); x.cyc = last_edge + TO;
      exp_q.push_back(x);
      mwords++;
      byte_q.delete();
      exp_done_lo = last_edge + TO + 1;
      exp_done_hi = last_edge + TO + 1;
    end else begin
      exp_done_lo = last_edge + TO;
      exp_done_hi = last_edge + TO + 1;
    end
  endtask

  task automatic send(input int idx, input logic [7:0] b, input int budget, output bit ok);
    int waited = 0;
    @(negedge clk);
    rvalid[idx] = 1'b1;
    rdata[idx]  = b;
    ok = 1'b0;
    while (!ok && waited < budget) begin
      if (rready[idx]) begin
        ok = 1'b1;
        model_accept(idx, b, cyc + 1);
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    rvalid[idx] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_rready", 32'(rready[k]), 32'd0);
    check("rst_we", 32'(we[k]), 32'd0);
    check("rst_addr", 32'(addr[k]), 32'd0);
    check("rst_wdata", wdata[k], 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst[k]), 32'd1);
    check("rst_done", 32'(done[k]), 32'd0);
    check("rst_words", 32'(words[k]), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rvalid[0] = 1'b0;
    rvalid[1] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check_reset_outputs(k);
    model_reset();
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rready_after_release", 32'(rready[k]), 32'd1);
      check("cpu_rst_after_release", 32'(cpu_rst[k]), 32'd1);
    end
  endtask

  task automatic finish_scenario(input int idx, input int exp_words, input int writes_before);
    int waited = 0;
    int de;
    while (!done[idx] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!done[idx]) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout inst%0d: done_o still 0 after %0d cycles, required 1", idx, waited);
    end
    repeat (2) @(negedge clk);
    de = get_done_edge(idx);
    if (exp_done_lo == exp_done_hi) begin
      check("done_edge", 32'(de), 32'(exp_done_lo));
    end else begin
      check("done_edge_window", 32'((de >= exp_done_lo) && (de <= exp_done_hi)), 32'd1);
    end
    check("final_words", 32'(words[idx]), 32'(exp_words));
    check("final_cpu_rst", 32'(cpu_rst[idx]), 32'd0);
    check("final_rready", 32'(rready[idx]), 32'd0);
    check("write_count", 32'(get_writes(idx) - writes_before), 32'(exp_words));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    int         w0;
    int         n_acc;
    int         n;
    logic [7:0] tbl [6];
    tbl[0] = 8'hAA; tbl[1] = 8'hBB; tbl[2] = 8'hCC;
    tbl[3] = 8'hDD; tbl[4] = 8'h11; tbl[5] = 8'h22;
    rvalid[0] = 1'b0; rvalid[1] = 1'b0;
    rdata[0]  = '0;   rdata[1]  = '0;
    #2;

    // Full image, back-to-back bytes 0x00..0x0F.
    do_reset();
    w0 = get_writes(0);
    for (int i = 0; i < 16; i++) send(0, 8'(i), 10, ok);
    finish_scenario(0, 4, w0);

    // Extra bytes beyond the image are never consumed.
    do_reset();
    w0 = get_writes(0);
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      send(0, 8'(i), 20, ok);
      if (ok) n_acc++;
    end
    check("extra_accepted", 32'(n_acc), 32'd16);
    finish_scenario(0, 4, w0);

    // Sparse source without timeout: one byte every 1000 cycles.
    do_reset();
    w0 = get_writes(0);
    for (int i = 0; i < 16; i++) begin
      repeat (999) @(negedge clk);
      send(0, 8'(i), 10, ok);
      if (i == 14) begin
        check("sparse_no_early_done", 32'(done[0]), 32'd0);
        check("sparse_words_mid", 32'(words[0]), 32'd3);
      end
    end
    check("no_timeout_before_first_byte", 32'(done[1]), 32'd0);
    finish_scenario(0, 4, w0);

    // Reset after 6 bytes, then a fresh randomized image with gaps.
    do_reset();
    for (int i = 0; i < 6; i++) send(0, 8'(8'h10 + i), 10, ok);
    check("pre_abort_words", 32'(words[0]), 32'd1);
    do_reset();
    w0 = get_writes(0);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(0, 8'($urandom_range(0, 255)), 10, ok);
    end
    finish_scenario(0, 4, w0);

    // Flush timeout: AA BB CC DD 11 22 then idle.
    do_reset();
    w0 = get_writes(1);
    for (int i = 0; i < 6; i++) send(1, tbl[i], 10, ok);
    model_flush(1);
    finish_scenario(1, 2, w0);

    // Aligned timeout: 4 bytes then idle, no second write.
    do_reset();
    w0 = get_writes(1);
    for (int i = 0; i < 4; i++) send(1, 8'($urandom_range(0, 255)), 10, ok);
    model_flush(1);
    finish_scenario(1, 1, w0);

    // Randomized partial images with short gaps, ended by the timeout.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      w0 = get_writes(1);
      n = $urandom_range(1, 15);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(1, 8'($urandom_range(0, 255)), 10, ok);
      end
      model_flush(1);
      finish_scenario(1, (n + 3) / 4, w0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
